// File: rtl/manchester_decoder_param.sv
// Manchester receiver: oversampled line, sync-bit framing, mid-bit timing window,
// MSB-first deserialisation into WORD_W-bit words with valid / frame-error strobes.
module manchester_decoder_param #(
  parameter int CNT_W  = 4,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              globalReset,
  input  logic              ManchesterCode,
  input  logic [CNT_W-1:0]  REF,
  input  logic              POLARITY,
  output logic              recoveredData,
  output logic              recoveredCLK,
  output logic [WORD_W-1:0] wordOut,
  output logic              wordValid,
  output logic              frameErr,
  output logic              locked
);
  localparam int TW  = CNT_W + 2;
  localparam int BCW = $clog2(WORD_W + 1);

  typedef enum logic {IDLE, DATA} state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic              edge_q, edge_d, dir_q, dir_d;
  logic              pol_q, pol_d, data_q, data_d, wvalid_q, wvalid_d, ferr_q, ferr_d;
  logic [TW-1:0]     h_q, h_d, quiet_q, quiet_d, timer_q, timer_d, rclk_q, rclk_d;
  logic [WORD_W-1:0] shift_q, shift_d, word_q, word_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;

  logic [TW-1:0]     ref_ext, two_h, win_lo, win_hi, t_now;
  logic              bit_val;

  always_comb begin
    ref_ext = TW'(REF);
    two_h   = h_q << 1;
    win_lo  = h_q + (h_q >> 1);
    win_hi  = two_h + (h_q >> 1);
    // cycles elapsed since the last accepted edge, counting the current one
    t_now   = timer_q + TW'(1);
    bit_val = dir_q ^ pol_q;
  end

  always_comb begin
    sync1_d  = ManchesterCode;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    edge_d   = sync2_q ^ hist_q;
    dir_d    = sync2_q;
    state_d  = state_q;
    h_d      = h_q;
    pol_d    = pol_q;
    quiet_d  = quiet_q;
    timer_d  = timer_q;
    shift_d  = shift_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    data_d   = data_q;
    rclk_d   = (rclk_q != '0) ? rclk_q - TW'(1) : '0;
    wvalid_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        h_d     = (ref_ext < TW'(4)) ? TW'(4) : ref_ext;
        pol_d   = POLARITY;
        timer_d = '0;
        bcnt_d  = '0;
        rclk_d  = '0;
        if (edge_q) begin
          quiet_d = '0;
          if (quiet_q == two_h && !bit_val) begin
            // freeze the settings the quiet check was made against
            state_d = DATA;
            h_d     = h_q;
            pol_d   = pol_q;
          end
        end else if (quiet_q < two_h) begin
          quiet_d = quiet_q + TW'(1);
        end else begin
          quiet_d = two_h;
        end
      end
      DATA: begin
        quiet_d = '0;
        timer_d = (&timer_q) ? timer_q : t_now;
        if (edge_q && t_now >= win_lo && t_now <= win_hi) begin
          timer_d = '0;
          shift_d = (shift_q << 1) | WORD_W'(bit_val);
          data_d  = bit_val;
          rclk_d  = h_q;
          if (bcnt_q == BCW'(WORD_W - 1)) begin
            word_d   = shift_d;
            wvalid_d = 1'b1;
            bcnt_d   = '0;
          end else begin
            bcnt_d = bcnt_q + BCW'(1);
          end
        end else if (t_now > win_hi) begin
          state_d = IDLE;
          rclk_d  = '0;
          bcnt_d  = '0;
          ferr_d  = (bcnt_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      hist_q   <= 1'b0;
      edge_q   <= 1'b0;
      dir_q    <= 1'b0;
      h_q      <= TW'(4);
      pol_q    <= 1'b0;
      quiet_q  <= '0;
      timer_q  <= '0;
      shift_q  <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
      data_q   <= 1'b0;
      rclk_q   <= '0;
      wvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      hist_q   <= hist_d;
      edge_q   <= edge_d;
      dir_q    <= dir_d;
      h_q      <= h_d;
      pol_q    <= pol_d;
      quiet_q  <= quiet_d;
      timer_q  <= timer_d;
      shift_q  <= shift_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      data_q   <= data_d;
      rclk_q   <= rclk_d;
      wvalid_q <= wvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  assign recoveredData = data_q;
  assign recoveredCLK  = (rclk_q != '0);
  assign wordOut       = word_q;
  assign wordValid     = wvalid_q;
  assign frameErr      = ferr_q;
  assign locked        = (state_q == DATA);

endmodule
